// File: rtl/count_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : count_seq_pkg
// Purpose  : Shared types and default constants for the count sequencer.
//            Holds the run-state encoding used by the FSM and the default
//            WIDTH / PRESCALE values picked up by count_sequencer and
//            count_core.
// Ports    : none (package)
// Config   : COUNT_SEQ_AUTORELOAD_EN (consumed by count_sequencer only)
// Revision : 1.0  initial release
// ============================================================================
package count_seq_pkg;

  // Default datapath width and clocks per count tick.
  localparam int c_DEF_WIDTH    = 8;
  localparam int c_DEF_PRESCALE = 1;

  // Run-state encoding. The values are fixed so that the state register
  // reads back identically across builds.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage : count_seq_pkg
`default_nettype wire

// File: rtl/count_core.sv
`default_nettype none
// ============================================================================
// Module   : count_core
// Purpose  : WIDTH-bit count register for the sequencer datapath.
//            Synchronous clear takes priority over the increment enable.
//            All sequencing decisions (when to clear, when to tick) are made
//            by count_sequencer; this block only stores and increments.
// Ports    : clk    in   1      rising-edge clock
//            reset  in   1      asynchronous reset, active-low
//            clr    in   1      synchronous clear to zero
//            en     in   1      increment by one (ignored when clr=1)
//            count  out  WIDTH  current count value
// Revision : 1.0  initial release
// ============================================================================
module count_core
  import count_seq_pkg::*;
#(
  parameter int WIDTH = c_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + c_ONE;
    end
  end

  assign count = r_count;

endmodule : count_core
`default_nettype wire

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : count_sequencer
// Purpose  : Run controller for the count datapath. On an accepted start it
//            latches the terminal value, then counts 0 -> term at one step
//            every PRESCALE clocks. Supports a level pause (count and
//            prescaler phase frozen) and an abort (stop). Flags completion
//            with a one-cycle done pulse.
//            Priority within a cycle: stop > pause > tick.
// Ports    : clk       in   1      rising-edge clock
//            reset     in   1      asynchronous reset, active-low
//            start     in   1      begin a run (honoured in IDLE only)
//            stop      in   1      abort a run, no done
//            pause     in   1      hold count while high
//            term_val  in   WIDTH  terminal count, latched on accepted start
//            count     out  WIDTH  current count
//            busy      out  1      high in RUN / PAUSED / DONE
//            done      out  1      one-cycle pulse on reaching terminal
// Config   : COUNT_SEQ_AUTORELOAD_EN
//              defined   : free-running; after showing term the count wraps
//                          to 0 on the next tick, done pulses each time term
//                          is reached, run ends only on stop or reset.
//              undefined : one-shot; stops in DONE for one cycle, then IDLE.
// Revision : 1.0  initial release
// ============================================================================
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH    = c_DEF_WIDTH,
  parameter int PRESCALE = c_DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  // Prescaler must hold 0..PRESCALE-1; keep at least one bit for PRESCALE=1.
  localparam int              c_PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(PRESCALE - 1);
  localparam logic [c_PW-1:0] c_PRESC_ONE  = {{(c_PW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [c_PW-1:0]  r_presc;
  logic [WIDTH-1:0] r_term;
  logic [WIDTH-1:0] w_inc;
  logic             w_accept;
  logic             w_active;
  logic             w_advance;
  logic             w_tick;
  logic             w_clr;
  logic             w_en;
`ifdef COUNT_SEQ_AUTORELOAD_EN
  logic             w_hit;
  logic             r_done;
`endif

  // --------------------------------------------------------------------------
  // Tick generation
  // --------------------------------------------------------------------------
  // PAUSED is left as soon as pause drops, and the prescaler advances on that
  // very edge, so a pause of N cycles delays the run by exactly N cycles.
  assign w_accept  = (r_state == S_IDLE) && start && !stop;
  assign w_active  = (r_state == S_RUN) || (r_state == S_PAUSED);
  assign w_advance = w_active && !stop && !pause;
  assign w_tick    = w_advance && (r_presc == c_PRESC_LAST);
  assign w_inc     = count + c_ONE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (w_accept) begin
      r_presc <= '0;
    end else if (w_advance) begin
      r_presc <= w_tick ? '0 : (r_presc + c_PRESC_ONE);
    end
  end

  // Terminal value is captured only on an accepted start; term_val is
  // don't-care for the rest of the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_term <= '0;
    end else if (w_accept) begin
      r_term <= term_val;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and datapath controls
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_en        = 1'b0;
`ifdef COUNT_SEQ_AUTORELOAD_EN
    w_hit       = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_clr = 1'b1;
`ifdef COUNT_SEQ_AUTORELOAD_EN
          w_state_nxt = S_RUN;
`else
          // A zero terminal is already reached: go straight to the done pulse.
          w_state_nxt = (term_val == '0) ? S_DONE : S_RUN;
`endif
        end
      end

      S_RUN, S_PAUSED: begin
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (pause) begin
          w_state_nxt = S_PAUSED;
        end else begin
          w_state_nxt = S_RUN;
          if (w_tick) begin
`ifdef COUNT_SEQ_AUTORELOAD_EN
            // Count shows term for one tick period, then wraps to 0.
            // done fires whenever the post-tick value equals term, which
            // makes term==0 pulse on every tick.
            if (count == r_term) begin
              w_clr = 1'b1;
              w_hit = (r_term == '0);
            end else begin
              w_en  = 1'b1;
              w_hit = (w_inc == r_term);
            end
`else
            // count < term throughout RUN, so the increment cannot wrap.
            w_en = 1'b1;
            if (w_inc == r_term) begin
              w_state_nxt = S_DONE;
            end
`endif
          end
        end
      end

      // stop is deliberately not looked at here: the done pulse completes.
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
`ifdef COUNT_SEQ_AUTORELOAD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_hit;
    end
  end

  assign done = r_done;
`else
  assign done = (r_state == S_DONE);
`endif

  assign busy = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // Count register
  // --------------------------------------------------------------------------
  count_core #(
    .WIDTH (WIDTH)
  ) u_count_core (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_en),
    .count (count)
  );

endmodule : count_sequencer
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_sequencer
// Purpose  : Self-checking bench for count_sequencer. Two instances share the
//            control inputs: one at PRESCALE=1, one at PRESCALE=4. A vector
//            table covers the single-cycle behaviour of the PRESCALE=1 unit;
//            hand-written sequences cover reset, prescaling, pause, stop and
//            (when COUNT_SEQ_AUTORELOAD_EN is defined) auto-reload.
// Revision : 1.0  initial release
// ============================================================================
module tb_count_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         pause = 1'b0;
  logic [W-1:0] term_val = '0;

  logic [W-1:0] count1;
  logic [W-1:0] count4;
  logic         busy1, done1, busy4, done4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic         start;
    logic         stop;
    logic         pause;
    logic [W-1:0] tv;
    logic [W-1:0] exp_count;
    logic         exp_busy;
    logic         exp_done;
  } vec_t;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(W), .PRESCALE(1)) u_dut_p1 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .term_val (term_val),
    .count    (count1),
    .busy     (busy1),
    .done     (done1)
  );

  count_sequencer #(.WIDTH(W), .PRESCALE(4)) u_dut_p4 (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .term_val (term_val),
    .count    (count4),
    .busy     (busy4),
    .done     (done4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiesce();
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b1;
    step();
    step();
    stop  = 1'b0;
  endtask

  initial begin
    vec_t tbl[14];

    // ---------------- power-on reset ----------------
    reset = 1'b1;
    #2 reset = 1'b0;
    step();
    check("por count1", count1, 0);
    check("por busy1", busy1, 0);
    check("por done1", done1, 0);
    check("por count4", count4, 0);
    #2 reset = 1'b1;
    step();
    check("idle busy1", busy1, 0);

`ifndef COUNT_SEQ_AUTORELOAD_EN
    // ---------------- one-shot vector table (PRESCALE=1) ----------------
    //            start stop pause tv     count busy done
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'd5,  8'd0, 1'b1, 1'b0};  // accept, term=5
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'd9,  8'd1, 1'b1, 1'b0};  // term_val change ignored
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'd9,  8'd2, 1'b1, 1'b0};  // start while running ignored
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'd0,  8'd3, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'd0,  8'd4, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'd0,  8'd5, 1'b1, 1'b1};  // terminal -> DONE
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'd0,  8'd5, 1'b0, 1'b0};  // stop in DONE ignored
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'd3,  8'd5, 1'b0, 1'b0};  // start+stop: stays IDLE
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'd0,  8'd0, 1'b1, 1'b1};  // term 0: done next cycle
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'd0,  8'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'd2,  8'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'd0,  8'd1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'd0,  8'd2, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 8'd0,  8'd2, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      start    = tbl[i].start;
      stop     = tbl[i].stop;
      pause    = tbl[i].pause;
      term_val = tbl[i].tv;
      step();
      check($sformatf("tbl[%0d] count", i), count1, tbl[i].exp_count);
      check($sformatf("tbl[%0d] busy", i), busy1, tbl[i].exp_busy);
      check($sformatf("tbl[%0d] done", i), done1, tbl[i].exp_done);
    end
    quiesce();
`endif

    // ---------------- reset mid-run ----------------
    start = 1'b1; term_val = 8'd200;
    step();
    start = 1'b0;
    repeat (9) step();
    check("prerst count1", count1, 9);
    check("prerst count4", count4, 2);
    #3 reset = 1'b0;
    #1;
    check("rst count1", count1, 0);
    check("rst busy1", busy1, 0);
    check("rst done1", done1, 0);
    check("rst count4", count4, 0);
    check("rst busy4", busy4, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst hold %0d count1", i), count1, 0);
      check($sformatf("rst hold %0d busy1", i), busy1, 0);
    end
    #2 reset = 1'b1;
    step();
    check("postrst busy1", busy1, 0);
    check("postrst count1", count1, 0);

`ifndef COUNT_SEQ_AUTORELOAD_EN
    // ---------------- PRESCALE=4, term=3 ----------------
    start = 1'b1; term_val = 8'd3;
    step();
    start = 1'b0;
    check("ps4 start count", count4, 0);
    check("ps4 start busy", busy4, 1);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("ps4 k=%0d count", k), count4, k / 4);
      check($sformatf("ps4 k=%0d done", k), done4, (k == 12) ? 1 : 0);
    end
    step();
    check("ps4 end busy", busy4, 0);
    check("ps4 end count", count4, 3);
    check("ps4 end done", done4, 0);
    quiesce();

    // ---------------- pause 6 cycles at count 4, term=10 ----------------
    start = 1'b1; term_val = 8'd10;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("pz run k=%0d count", k), count1, k);
    end
    pause = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("pz hold %0d count", k), count1, 4);
      check($sformatf("pz hold %0d busy", k), busy1, 1);
      check($sformatf("pz hold %0d done", k), done1, 0);
    end
    pause = 1'b0;
    for (int k = 5; k <= 10; k++) begin
      step();
      check($sformatf("pz resume k=%0d count", k), count1, k);
      check($sformatf("pz resume k=%0d done", k), done1, (k == 10) ? 1 : 0);
    end
    step();
    check("pz end busy", busy1, 0);
    check("pz end count", count1, 10);
    quiesce();
`endif

    // ---------------- stop at count 50, term=200 ----------------
    start = 1'b1; term_val = 8'd200;
    step();
    start = 1'b0;
    check("stop start count", count1, 0);
    check("stop start busy", busy1, 1);
    for (int k = 1; k <= 50; k++) begin
      step();
      check($sformatf("stop run k=%0d done", k), done1, 0);
    end
    check("stop pre count1", count1, 50);
    check("stop pre count4", count4, 12);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop count1", count1, 50);
    check("stop busy1", busy1, 0);
    check("stop done1", done1, 0);
    check("stop count4", count4, 12);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stop idle %0d count", k), count1, 50);
      check($sformatf("stop idle %0d done", k), done1, 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart count", count1, 0);
    check("restart busy", busy1, 1);
    step();
    check("restart step count", count1, 1);
    quiesce();

`ifdef COUNT_SEQ_AUTORELOAD_EN
    // ---------------- auto-reload, term=2 ----------------
    start = 1'b1; term_val = 8'd2;
    step();
    start = 1'b0;
    check("ar start count", count1, 0);
    check("ar start done", done1, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("ar k=%0d count", k), count1, k % 3);
      check($sformatf("ar k=%0d done", k), done1, ((k % 3) == 2) ? 1 : 0);
      check($sformatf("ar k=%0d busy", k), busy1, 1);
    end
    quiesce();

    // ---------------- auto-reload, term=0 ----------------
    start = 1'b1; term_val = 8'd0;
    step();
    start = 1'b0;
    check("ar0 start count", count1, 0);
    check("ar0 start busy", busy1, 1);
    check("ar0 start done", done1, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("ar0 %0d count", k), count1, 0);
      check($sformatf("ar0 %0d done", k), done1, 1);
    end
    quiesce();
    check("ar0 stopped busy", busy1, 0);
    check("ar0 stopped done", done1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_count_sequencer
`default_nettype wire
